apb_csr_bank: RTL and testbench

Parametrised APB4 control/status register bank: generalises the fixed single-control/single-status register block to NUM_CTRL read/write control words and NUM_STAT read-only status words, plus an ID register and a maskable sticky event/interrupt pair. It sits on an APB peripheral slot between the fabric interconnect and user logic. It adds byte strobes, error response on bad accesses, status sampling, rising-edge event capture with write-1-to-clear, and an interrupt output.

---
 rtl/apb_csr_bank.sv | 200 ++++++++++++++++++++
 tb/tb_apb_csr_bank.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_csr_bank.sv
// ----------------------------------------------------------------------------
// apb_csr_bank
//
// APB4 control/status register bank with NUM_CTRL read/write control words,
// NUM_STAT read-only status words, a constant ID register and a sticky
// event-pending / mask pair that drives a level interrupt.
//
// Register map (byte address, word aligned):
//   0x00          ID        (RO)   returns ID_VALUE
//   0x04          EVT_PEND  (RW1C) rising edges of status word 0
//   0x08          EVT_MASK  (RW)   interrupt enable per pending bit
//   0x10 + 4*i    CONTROL_i (RW)   i < NUM_CTRL
//   0x40 + 4*j    STATUS_j  (RO)   j < NUM_STAT
// Misaligned, unmapped or out-of-range addresses and writes to RO registers
// answer with pslverr=1 and read data 0, and change nothing.
//
// Ports:
//   pclk, presetn      clock and synchronous active-low reset
//   psel, penable, paddr, pwrite, pwdata, pstrb
//                      APB4 request (zero-wait slave)
//   prdata, pready, pslverr
//                      APB4 response; prdata/pslverr registered at setup
//   control            NUM_CTRL packed 32-bit control words
//   status             NUM_STAT packed 32-bit status words (pclk domain)
//   irq                registered level interrupt = |(pend & mask)
// ----------------------------------------------------------------------------
module apb_csr_bank #(
    parameter int          NUM_CTRL   = 4,
    parameter int          NUM_STAT   = 2,
    parameter logic [31:0] ID_VALUE   = 32'hDEADBEEF,
    parameter logic [31:0] CTRL_RESET = 32'h00000000
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic                     psel,
    input  logic                     penable,
    input  logic [7:0]               paddr,
    input  logic                     pwrite,
    input  logic [31:0]              pwdata,
    input  logic [3:0]               pstrb,
    output logic [31:0]              prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [NUM_CTRL*32-1:0]   control,
    input  logic [NUM_STAT*32-1:0]   status,
    output logic                     irq
);

    logic [NUM_CTRL-1:0][31:0] ctrl_q, ctrl_d;
    logic [31:0]               mask_q, mask_d;
    logic [31:0]               pend_q, pend_d;
    logic [NUM_STAT*32-1:0]    status_q, status_d;
    logic [31:0]               status_qq, status_qq_d;
    logic [31:0]               prdata_q, prdata_d;
    logic                      pslverr_q, pslverr_d;
    logic                      irq_q, irq_d;

    // Address decode results
    logic [5:0]          word_idx;
    logic                hit;
    logic                read_only;
    logic                sel_pend;
    logic                sel_mask;
    logic [NUM_CTRL-1:0] sel_ctrl;
    logic [31:0]         rd_word;
    logic                acc_err;

    logic                setup;
    logic                wr_commit;
    logic [31:0]         bmask;
    logic [31:0]         clr;
    logic [31:0]         rise;

    // ------------------------------------------------------------------
    // Decode: the same decode serves the setup phase (read data/error
    // capture) and the access phase (write commit), since paddr is held
    // stable across both phases of a transfer.
    // ------------------------------------------------------------------
    always_comb begin
        word_idx  = paddr[7:2];
        hit       = 1'b0;
        read_only = 1'b0;
        sel_pend  = 1'b0;
        sel_mask  = 1'b0;
        sel_ctrl  = '0;
        rd_word   = 32'h0;

        if (word_idx == 6'd0) begin
            hit       = 1'b1;
            read_only = 1'b1;
            rd_word   = ID_VALUE;
        end
        if (word_idx == 6'd1) begin
            hit      = 1'b1;
            sel_pend = 1'b1;
            rd_word  = pend_q;
        end
        if (word_idx == 6'd2) begin
            hit      = 1'b1;
            sel_mask = 1'b1;
            rd_word  = mask_q;
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (word_idx == 6'(4 + i)) begin
                hit         = 1'b1;
                sel_ctrl[i] = 1'b1;
                rd_word     = ctrl_q[i];
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (word_idx == 6'(16 + j)) begin
                hit       = 1'b1;
                read_only = 1'b1;
                rd_word   = status_q[32*j +: 32];
            end
        end

        acc_err = (paddr[1:0] != 2'b00) | ~hit | (read_only & pwrite);
    end

    assign setup     = psel & ~penable;
    assign wr_commit = psel & penable & pwrite & ~acc_err;
    assign bmask     = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Response: captured only at setup; pslverr is a one-transfer pulse,
        // prdata is held so it stays readable through the access phase.
        prdata_d  = prdata_q;
        pslverr_d = 1'b0;
        if (setup) begin
            pslverr_d = acc_err;
            prdata_d  = (pwrite | acc_err) ? 32'h0 : rd_word;
        end

        ctrl_d = ctrl_q;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (wr_commit && sel_ctrl[i]) begin
                ctrl_d[i] = (ctrl_q[i] & ~bmask) | (pwdata & bmask);
            end
        end

        mask_d = mask_q;
        if (wr_commit && sel_mask) begin
            mask_d = (mask_q & ~bmask) | (pwdata & bmask);
        end

        // Two-stage status history gives the edge detector on word 0;
        // a newly detected rise overrides a same-cycle write-1-to-clear.
        status_d    = status;
        status_qq_d = status_q[31:0];
        rise        = status_q[31:0] & ~status_qq;
        clr         = (wr_commit && sel_pend) ? (pwdata & bmask) : 32'h0;
        pend_d      = (pend_q & ~clr) | rise;

        irq_d = |(pend_q & mask_q);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            ctrl_q    <= {NUM_CTRL{CTRL_RESET}};
            mask_q    <= 32'h0;
            pend_q    <= 32'h0;
            status_q  <= '0;
            status_qq <= 32'h0;
            prdata_q  <= 32'h0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            status_q  <= status_d;
            status_qq <= status_qq_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl_out
            assign control[32*gi +: 32] = ctrl_q[gi];
        end
    endgenerate

    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;
    assign pready  = 1'b1;
    assign irq     = irq_q;

endmodule

// File: tb/tb_apb_csr_bank.sv
// ----------------------------------------------------------------------------
// tb_apb_csr_bank
//
// Self-checking bench for apb_csr_bank. Stimulus tasks push the expected
// APB response (read data, error flag) into a scoreboard queue computed from
// an address-map reference model; a monitor pops and compares on every
// access phase. Directed sequences cover reset, byte strobes, error
// responses, event/irq timing, set-wins-over-clear and reset mid-transfer,
// followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_apb_csr_bank;

    localparam int          NC  = 4;
    localparam int          NS  = 2;
    localparam logic [31:0] IDV = 32'hDEADBEEF;
    localparam logic [31:0] CRV = 32'h00000000;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              psel;
    logic              penable;
    logic [7:0]        paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [NC*32-1:0]  control;
    logic [NS*32-1:0]  status;
    logic              irq;

    always #5 pclk = ~pclk;

    apb_csr_bank #(
        .NUM_CTRL   (NC),
        .NUM_STAT   (NS),
        .ID_VALUE   (IDV),
        .CTRL_RESET (CRV)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .control (control),
        .status  (status),
        .irq     (irq)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;

    // Reference model state
    logic [31:0] ctrl_m [NC];
    logic [31:0] mask_m;
    logic [31:0] pend_m;
    logic [31:0] stat_m [NS];

    logic [7:0] addrs [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                               8'h20, 8'h3C, 8'h40, 8'h44, 8'h48, 8'h7C, 8'h80, 8'hFC};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] bytemask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] irq_exp();
        return {31'b0, |(pend_m & mask_m)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) ctrl_m[i] = CRV;
        mask_m = 32'h0;
        pend_m = 32'h0;
    endtask

    // Register-map level model of one APB transfer: returns the response and
    // applies any write effect.
    task automatic model_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] rd, output logic err);
        int          word;
        bit          ok;
        bit          ro;
        logic [31:0] val;
        logic [31:0] bm;
        word = int'(a) / 4;
        ok   = 0;
        ro   = 0;
        val  = 32'h0;
        bm   = bytemask(s);
        if (word == 0) begin ok = 1; ro = 1; val = IDV; end
        else if (word == 1) begin ok = 1; val = pend_m; end
        else if (word == 2) begin ok = 1; val = mask_m; end
        else if (word >= 4 && word < 4 + NC) begin ok = 1; val = ctrl_m[word-4]; end
        else if (word >= 16 && word < 16 + NS) begin ok = 1; ro = 1; val = stat_m[word-16]; end
        err = ((int'(a) % 4) != 0) || !ok || (ro && w);
        rd  = (w || err) ? 32'h0 : val;
        if (w && !err) begin
            if (word == 1)      pend_m = pend_m & ~(d & bm);
            else if (word == 2) mask_m = (mask_m & ~bm) | (d & bm);
            else                ctrl_m[word-4] = (ctrl_m[word-4] & ~bm) | (d & bm);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the access edge
    // with the bus idle, so consecutive calls run back-to-back.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        model_access(w, a, d, s, e.rd, e.err);
        sb.push_back(e);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic drive_status();
        status = {stat_m[1], stat_m[0]};
    endtask

    // Monitor: every access phase is a completed transfer (pready=1).
    always @(negedge pclk) begin
        exp_t e;
        if (psel && penable) begin
            n_txn++;
            $display("txn %0d: %s addr=%h prdata=%h pslverr=%0d", n_txn,
                     pwrite ? "WR" : "RD", paddr, prdata, pslverr);
            chk("pready", {31'b0, pready}, 32'd1);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_empty: response with no expected entry, prdata=%h", prdata);
            end else begin
                e = sb.pop_front();
                chk("prdata", prdata, e.rd);
                chk("pslverr", {31'b0, pslverr}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        ab;
        logic [7:0]  a;
        logic        w;
        logic [31:0] n0;

        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        for (int j = 0; j < NS; j++) stat_m[j] = 32'h0;
        drive_status();
        model_reset();

        // Reset state
        idle(3);
        chk("rst_control", control[31:0] | control[63:32] | control[95:64] | control[127:96], CRV);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
        presetn = 1'b1;
        idle(1);

        // ID and control reset values
        xfer(1'b0, 8'h00, 32'h0, 4'h0);
        for (int i = 0; i < NC; i++) xfer(1'b0, 8'(16 + 4 * i), 32'h0, 4'h0);

        // Byte strobes
        xfer(1'b1, 8'h14, 32'hA5A5A5A5, 4'b0101);
        chk("ctrl1_strb", control[63:32], 32'h00A500A5);
        xfer(1'b0, 8'h14, 32'h0, 4'h0);

        // Error responses leave registers alone
        xfer(1'b0, 8'h03, 32'h0, 4'h0);
        xfer(1'b1, 8'h40, 32'hFFFFFFFF, 4'hF);
        xfer(1'b0, 8'h20, 32'h0, 4'h0);
        xfer(1'b1, 8'h00, 32'hFFFFFFFF, 4'hF);
        xfer(1'b1, 8'h11, 32'hFFFFFFFF, 4'hF);
        chk("ctrl0_after_err", control[31:0], CRV);
        chk("ctrl1_after_err", control[63:32], 32'h00A500A5);

        // Event on status bit 3 with mask bit 3
        xfer(1'b1, 8'h08, 32'h8, 4'hF);
        idle(1);
        stat_m[0] = 32'h8;
        drive_status();
        pend_m = pend_m | 32'h8;
        idle(1);
        chk("irq_E0", {31'b0, irq}, 32'd0);
        idle(1);
        chk("irq_E1", {31'b0, irq}, 32'd0);
        idle(1);
        chk("irq_E2", {31'b0, irq}, 32'd1);
        xfer(1'b0, 8'h04, 32'h0, 4'h0);
        xfer(1'b1, 8'h04, 32'h8, 4'hF);
        chk("irq_hold", {31'b0, irq}, 32'd1);
        idle(1);
        chk("irq_drop", {31'b0, irq}, 32'd0);
        xfer(1'b0, 8'h04, 32'h0, 4'h0);

        // Set wins over a same-cycle clear
        stat_m[0] = 32'h0; drive_status(); idle(3);
        stat_m[0] = 32'h8; drive_status(); pend_m = pend_m | 32'h8; idle(3);
        chk("irq_reevent", {31'b0, irq}, irq_exp());
        stat_m[0] = 32'h0; drive_status(); idle(3);
        stat_m[0] = 32'h8; drive_status();
        xfer(1'b1, 8'h04, 32'h8, 4'hF);
        pend_m = pend_m | 32'h8;
        idle(1);
        chk("irq_setwins", {31'b0, irq}, 32'd1);
        xfer(1'b0, 8'h04, 32'h0, 4'h0);

        // Reset asserted during a write access phase
        stat_m[0] = 32'h0; drive_status(); idle(3);
        xfer(1'b1, 8'h10, 32'h12345678, 4'hF);
        chk("ctrl0_pre_abort", control[31:0], 32'h12345678);
        ab.rd  = 32'h0;
        ab.err = 1'b0;
        sb.push_back(ab);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        presetn = 1'b0;
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
        model_reset();
        chk("abort_ctrl0", control[31:0], CRV);
        chk("abort_prdata", prdata, 32'd0);
        chk("abort_pslverr", {31'b0, pslverr}, 32'd0);
        chk("abort_irq", {31'b0, irq}, 32'd0);
        idle(1);
        presetn = 1'b1;
        idle(1);
        xfer(1'b0, 8'h10, 32'h0, 4'h0);
        xfer(1'b0, 8'h04, 32'h0, 4'h0);

        // Randomized phase
        for (int k = 0; k < 160; k++) begin
            if (k % 10 == 0) begin
                n0 = $urandom;
                pend_m = pend_m | (n0 & ~stat_m[0]);
                stat_m[0] = n0;
                stat_m[1] = $urandom;
                drive_status();
                idle(3);
                chk("irq_rand_evt", {31'b0, irq}, irq_exp());
            end
            a = addrs[$urandom_range(0, 15)];
            if ($urandom_range(0, 7) == 0) a = a | 8'($urandom_range(1, 3));
            w = 1'($urandom_range(0, 1));
            xfer(w, a, $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) idle(1);
            if (k % 8 == 7) begin
                idle(2);
                chk("irq_rand", {31'b0, irq}, irq_exp());
            end
        end

        // Drain scoreboard
        for (int t = 0; t < 10 && sb.size() != 0; t++) idle(1);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
